// File: rtl/prog_lut_pkg.sv
// Shared types, default sizes and the power-up image for the programmable lookup table.
package prog_lut_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Entries not listed power up as zero; callers resize the result to their data width.
  function automatic logic [31:0] default_image(input logic [31:0] addr);
    logic [31:0] val;
    val = 32'h0;
    case (addr)
      32'd1:  val = 32'h255;
      32'd2:  val = 32'h126;
      32'd3:  val = 32'h127;
      32'd4:  val = 32'h128;
      32'd5:  val = 32'h129;
      32'd6:  val = 32'h130;
      32'd7:  val = 32'h9;
      32'd8:  val = 32'h10;
      32'd9:  val = 32'h32;
      32'd10: val = 32'h96;
      32'd17: val = 32'h1;
      32'd18: val = 32'h2;
      32'd19: val = 32'h3;
      32'd20: val = 32'h4;
      32'd21: val = 32'h5;
      32'd22: val = 32'h6;
      32'd23: val = 32'h7;
      32'd24: val = 32'h8;
      32'd25: val = 32'h12;
      default: val = 32'h0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/prog_lut_mem.sv
// Table storage: one synchronous write port, one asynchronous read port.
module lut_mem
  import prog_lut_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_lut.sv
// Programmable lookup table that loads its default image after reset, then serves
// one registered read and one write per cycle with write-first bypass.
module prog_lut
  import prog_lut_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic [DATA_W-1:0] Target,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              ready_reg;
  logic              rd_valid_reg;
  logic [DATA_W-1:0] target_reg;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              init_last;
  logic              bypass;

  // While loading, the init counter owns the write port; user writes are shut out.
  always_comb begin
    mem_we    = wr_en;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_reg == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_reg;
      mem_wdata = DATA_W'(default_image(32'(cnt_reg)));
    end
  end

  assign init_last = (cnt_reg == ADDR_W'(DEPTH - 1));
  assign bypass    = wr_en && (wr_addr == rd_addr);

  lut_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .Clk  (Clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(rd_addr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= INIT;
      cnt_reg      <= '0;
      ready_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      target_reg   <= '0;
    end else begin
      case (state_reg)
        INIT: begin
          rd_valid_reg <= 1'b0;
          cnt_reg      <= cnt_reg + 1'b1;
          // Terminate on the last entry rather than on wrap so INIT is exactly DEPTH cycles.
          if (init_last) begin
            state_reg <= READY;
            ready_reg <= 1'b1;
          end
        end
        READY: begin
          rd_valid_reg <= rd_en;
          if (rd_en) begin
            target_reg <= bypass ? wr_data : mem_rdata;
          end
        end
        default: begin
          state_reg <= INIT;
          cnt_reg   <= '0;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_reg;
  assign rd_valid = rd_valid_reg;
  assign Target   = target_reg;

endmodule

// File: tb/tb_prog_lut.sv
// Directed self-checking bench for prog_lut with hand-computed expected values.
module tb_prog_lut;

  logic        Clk;
  logic        Reset;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        ready;
  logic [15:0] Target;
  logic        rd_valid;

  int tests;
  int fails;

  prog_lut #(.ADDR_W(5), .DATA_W(16)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ready   (ready),
    .Target  (Target),
    .rd_valid(rd_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] exp_image(input int a);
    logic [15:0] v;
    case (a)
      1: v = 16'h0255;  2: v = 16'h0126;  3: v = 16'h0127;  4: v = 16'h0128;
      5: v = 16'h0129;  6: v = 16'h0130;  7: v = 16'h0009;  8: v = 16'h0010;
      9: v = 16'h0032;  10: v = 16'h0096; 17: v = 16'h0001; 18: v = 16'h0002;
      19: v = 16'h0003; 20: v = 16'h0004; 21: v = 16'h0005; 22: v = 16'h0006;
      23: v = 16'h0007; 24: v = 16'h0008; 25: v = 16'h0012;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      check({tag, "_rdvalid_low"}, 32'(rd_valid), 32'd0);
      @(negedge Clk);
      n++;
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd31);
    check({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    Reset   = 1'b1;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    @(negedge Clk);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rdvalid", 32'(rd_valid), 32'd0);
    check("reset_target", 32'(Target), 32'd0);

    // Requests during INIT must be ignored; ready stays low for 32 cycles total.
    Reset   = 1'b0;
    rd_en   = 1'b1;
    rd_addr = 5'd2;
    wr_en   = 1'b1;
    wr_addr = 5'd2;
    wr_data = 16'hFFFF;
    @(negedge Clk);
    wait_init("init");
    check("init_target_held", 32'(Target), 32'd0);
    rd_en = 1'b0;
    wr_en = 1'b0;

    // Back-to-back read of the whole image.
    for (int a = 0; a < 32; a++) begin
      rd_en   = 1'b1;
      rd_addr = 5'(a);
      @(negedge Clk);
      check($sformatf("image_rd%0d", a), 32'(Target), 32'(exp_image(a)));
      check($sformatf("image_vld%0d", a), 32'(rd_valid), 32'd1);
    end
    rd_en = 1'b0;
    @(negedge Clk);
    check("idle_rdvalid", 32'(rd_valid), 32'd0);

    // Same-address read/write: write-first bypass.
    rd_en = 1'b1; rd_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 16'hBEEF;
    @(negedge Clk);
    check("bypass_target", 32'(Target), 32'h0000BEEF);
    check("bypass_vld", 32'(rd_valid), 32'd1);
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge Clk);
    check("hold_target", 32'(Target), 32'h0000BEEF);
    check("hold_rdvalid", 32'(rd_valid), 32'd0);
    rd_en = 1'b1; rd_addr = 5'd6;
    @(negedge Clk);
    check("rd6_after_wr7", 32'(Target), 32'h00000130);
    rd_addr = 5'd7;
    @(negedge Clk);
    check("reread7", 32'(Target), 32'h0000BEEF);

    // Different-address read/write: old read data, write completes.
    rd_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h1111;
    @(negedge Clk);
    check("rd4_during_wr3", 32'(Target), 32'h00000128);
    wr_en = 1'b0;
    rd_addr = 5'd3;
    @(negedge Clk);
    check("reread3", 32'(Target), 32'h00001111);
    rd_addr = 5'd2;
    @(negedge Clk);
    check("rd2_init_ignored", 32'(Target), 32'h00000126);
    rd_en = 1'b0;

    // Reset during traffic restarts the full initialization.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'hAAAA;
    @(negedge Clk);
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd9;
    @(negedge Clk);
    check("rd9_written", 32'(Target), 32'h0000AAAA);
    Reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'h5555;
    @(negedge Clk);
    check("rst2_target", 32'(Target), 32'd0);
    check("rst2_ready", 32'(ready), 32'd0);
    check("rst2_rdvalid", 32'(rd_valid), 32'd0);
    Reset = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(negedge Clk);
    wait_init("reinit");
    rd_en = 1'b1; rd_addr = 5'd9;
    @(negedge Clk);
    check("rd9_after_reinit", 32'(Target), 32'h00000032);
    rd_addr = 5'd7;
    @(negedge Clk);
    check("rd7_after_reinit", 32'(Target), 32'h00000009);
    rd_en = 1'b0;
    @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_lut.md
PROG_LUT -- requirements
Module: prog_lut

Interface
REQ-001 Parameter ADDR_W, default 5, address width; table depth is DEPTH = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 16, width of each stored target.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 rd_en  input  1  read request, sampled on Clk.
REQ-006 rd_addr  input  ADDR_W  read address.
REQ-007 wr_en  input  1  write request, sampled on Clk.
REQ-008 wr_addr  input  ADDR_W  write address.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 ready  output  1  high when the table accepts reads and writes.
REQ-011 Target  output  DATA_W  registered read data.
REQ-012 rd_valid  output  1  high for one cycle when Target holds data for an accepted read.

Function
REQ-013 The block SHALL implement a two-state FSM: INIT and READY.
REQ-014 INIT: an ADDR_W-bit init counter starts at 0 and writes default_image(counter) into the entry at counter each cycle; the counter increments by 1.
REQ-015 INIT->READY transition SHALL occur on the cycle after the write of entry DEPTH-1; INIT lasts exactly DEPTH cycles; counter wrap to 0 is not used as a terminal condition.
REQ-016 ready SHALL be 1 only in READY and is a registered output.
REQ-017 In INIT, rd_en and wr_en SHALL be ignored: no table change from the write port, rd_valid=0, Target unchanged.
REQ-018 Read latency SHALL be 1 cycle: rd_en=1 in READY at edge N gives Target=table[rd_addr] and rd_valid=1 after edge N+1.
REQ-019 rd_valid SHALL be 0 in any cycle following an edge without an accepted read; Target holds its last value.
REQ-020 Write: wr_en=1 in READY updates table[wr_addr]<=wr_data at that edge; no other entry changes.
REQ-021 A simultaneous read and write to the same address SHALL return wr_data on Target (write-first bypass).
REQ-022 A simultaneous read and write to different addresses SHALL return the old read-address contents and complete the write.
REQ-023 Back-to-back reads every cycle SHALL produce rd_valid=1 every cycle; throughput is 1 read and 1 write per cycle.
REQ-024 Default image (DATA_W=16, all others 0): 1->0x255, 2->0x126, 3->0x127, 4->0x128, 5->0x129, 6->0x130, 7->0x9, 8->0x10, 9->0x32, 10->0x96, 17->0x1, 18->0x2, 19->0x3, 20->0x4, 21->0x5, 22->0x6, 23->0x7, 24->0x8, 25->0x12.
REQ-025 Image values SHALL be zero-extended or truncated to DATA_W; image addresses >= DEPTH SHALL be dropped.

Reset
REQ-026 Reset=1 SHALL force state=INIT, init counter=0, ready=0, rd_valid=0, Target=0.
REQ-027 Reset asserted at any time, including mid-INIT or during READY traffic, SHALL abort pending operations and restart the full DEPTH-cycle initialization after deassertion.
REQ-028 Table contents are not cleared by Reset directly; INIT overwrites every entry.

Structure
REQ-029 A shared package SHALL hold the state enum (INIT, READY), the ADDR_W/DATA_W defaults and the default_image function.
REQ-030 Storage SHALL be a sub-module lut_mem: DEPTH x DATA_W, one synchronous write port and one asynchronous read port; bypass and output registers live in prog_lut.
REQ-031 The write-port mux (init counter/image vs. wr_addr/wr_data) SHALL be selected by state.

Verification
REQ-032 Reset 1 cycle, release -> ready=0 for exactly 32 cycles then 1; rd_valid=0 throughout.
REQ-033 After init, read addresses 0..31 back-to-back -> Target equals REQ-024 image one cycle later (e.g. addr 1 -> 0x0255, addr 25 -> 0x0012, addr 31 -> 0x0000), rd_valid=1 each cycle.
REQ-034 Write addr 7 data 0xBEEF and read addr 7 in same cycle -> Target=0xBEEF next cycle; later read addr 7 -> 0xBEEF.
REQ-035 Write addr 3 data 0x1111 while reading addr 4 -> Target=0x0128; next read addr 3 -> 0x1111.
REQ-036 Assert wr_en/rd_en during INIT at addr 2 data 0xFFFF -> ignored; after ready, read addr 2 -> 0x0126.
REQ-037 Write addr 9 to 0xAAAA, assert Reset mid-traffic -> Target=0, ready=0, and after 32 cycles read addr 9 -> 0x0032.
